ml_ahb_arb_port_1: RTL and testbench
====================================

Name: ml_ahb_arb_port_1

Overview:
Per-slave-port arbiter for port 1 of the multi-layer AHB matrix; two masters (master 0, master 1) share the port.
- Consumes the one-hot priority winner from the port-1 priority decoder and the per-master request lines.
- Produces a registered address-phase grant and a data-phase master select.
- Holds ownership across fixed-length bursts, undefined-length INCR bursts and locked sequences.
- Sits between the priority decoder and the port's address/data multiplexers.

Parameters:
DEF_MASTER, 0, master parked on the port after reset and when no request is pending (0 or 1)
CNT_W, 4, width of the burst beat counter (must hold 15)

Ports:
HCLK  input  1  port clock
HRESETn  input  1  reset; synchronous, active-low
req  input  2  per-master request to port 1; bit i = master i
decod  input  2  one-hot priority winner from the priority decoder; 2'b01 = master 0, 2'b10 = master 1
hready  input  1  port HREADY (transfer accepted / data phase ends)
htrans  input  2  HTRANS of the currently granted master (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
hburst  input  3  HBURST of the currently granted master (SINGLE=000, INCR=001, WRAP4/INCR4=01x, WRAP8/INCR8=10x, WRAP16/INCR16=11x)
hmastlock  input  1  HMASTLOCK of the currently granted master
grant  output  2  one-hot address-phase grant, registered
addr_sel  output  1  index of the granted master (encoded grant), registered
data_sel  output  1  index of the master owning the current data phase, registered
locked  output  1  high while state = LOCK

Behaviour:
- Reset (HRESETn=0 at a HCLK edge): state=ARB; grant=one-hot(DEF_MASTER); addr_sel=DEF_MASTER; data_sel=DEF_MASTER; beat counter=0; locked=0. Reset mid-burst or mid-lock aborts the sequence immediately.
- All state changes occur only on edges where hready=1. When hready=0, every register holds.
- Winner selection (combinational): req=11 -> decod; req=01 -> master 0; req=10 -> master 1; req=00 -> keep current owner (park). A decod value other than 01 or 10 with req=11 selects master 0.
- Priority of decisions each hready=1 edge: lock > burst hold > arbitrate.
- States:
  - ARB: grant/addr_sel <= winner.
    - If the current owner presents NONSEQ with hmastlock=1 -> LOCK; grant held.
    - Else if NONSEQ with a fixed burst -> BURST; counter <= beats-1 (3/7/15); grant held.
    - Else if NONSEQ with INCR -> INCR; grant held.
    - SINGLE or IDLE -> stay in ARB.
  - BURST:
    - SEQ -> counter decrements; on the SEQ accepted with counter=1, go to ARB (the next edge re-arbitrates).
    - BUSY -> counter holds.
    - IDLE or NONSEQ (early termination) -> ARB, with a same-edge re-arbitration.
  - INCR: SEQ/BUSY hold; IDLE or NONSEQ -> ARB with a same-edge re-arbitration.
  - LOCK: grant held regardless of req/decod; exit to ARB when hmastlock=0 and htrans=IDLE.
- data_sel <= addr_sel on every hready=1 edge, giving exactly 1 accepted-transfer of latency versus addr_sel.
- grant and addr_sel are always consistent; grant is never 00 or 11.
- A change of decod while not in ARB has no effect.

Decomposition:
- Package ml_ahb_pkg: HTRANS and HBURST code constants, the state encoding (ARB, BURST, INCR, LOCK), and a beats-from-HBURST function.
- One sub-module: ml_ahb_burst_cnt. It loads, decrements, holds and flags last beat; hready-qualified.
- The arbiter FSM and the grant/select registers stay in the top module.

Test Plan:
- Reset with DEF_MASTER=0, req=00 -> grant=01, addr_sel=0, data_sel=0, locked=0.
- req=11, decod=10, hready=1, htrans=SINGLE NONSEQ on every cycle -> grant=10 next edge and stays 10; switching decod to 01 -> grant=01 one edge later.
- Master 0 owns the port and issues INCR4 (NONSEQ + 3 SEQ); req=11 with decod=10 throughout -> grant stays 01 for all 4 beats and changes to 10 on the edge after the 4th beat. Inserting a BUSY at beat 2 extends the hold by 1 cycle.
- INCR8 aborted by IDLE after 3 beats with req=10 -> state ARB and grant=10 on that same edge.
- hmastlock=1 on master 1 across 3 SINGLE transfers, with req=11 and decod=01 -> grant=10 and locked=1 throughout; released one edge after hmastlock=0 with IDLE.
- hready=0 for 5 cycles mid-burst with decod toggling -> grant, addr_sel, data_sel and the counter are unchanged. HRESETn=0 during that stall -> grant=01 on the next edge.

Source files
------------

// File: rtl/ml_ahb_pkg.sv
// Shared AHB transfer/burst codes, arbiter state encoding and burst-length
// helper for the multi-layer AHB matrix port arbiters.
package ml_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  localparam int unsigned BEAT_W = 4;

  typedef enum logic [1:0] {
    ST_ARB   = 2'b00,
    ST_BURST = 2'b01,
    ST_INCR  = 2'b10,
    ST_LOCK  = 2'b11
  } arb_state_e;

  // Remaining beats after the NONSEQ of a fixed-length burst (HBURST[2:1]).
  function automatic logic [BEAT_W-1:0] burst_beats_m1(input logic [1:0] burst_len);
    case (burst_len)
      2'b01:   return BEAT_W'(3);
      2'b10:   return BEAT_W'(7);
      2'b11:   return BEAT_W'(15);
      default: return BEAT_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/ml_ahb_burst_cnt.sv
// Beat counter for fixed-length bursts; every update is qualified by hready.
module ml_ahb_burst_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hready,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             clr,
  output logic             last_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (hready) begin
      if (load) begin
        cnt <= load_val;
      end else if (clr) begin
        cnt <= '0;
      end else if (dec && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Final SEQ of the burst is the one accepted while one beat remains.
  assign last_c = (cnt == CNT_W'(1));

endmodule

// File: rtl/ml_ahb_arb_port_1.sv
// Two-master arbiter for slave port 1: registered address-phase grant and
// data-phase select, holding ownership across bursts and locked sequences.
module ml_ahb_arb_port_1
  import ml_ahb_pkg::*;
#(
  parameter int unsigned DEF_MASTER = 0,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic [1:0] req,
  input  logic [1:0] decod,
  input  logic       hready,
  input  logic [1:0] htrans,
  input  logic [2:0] hburst,
  input  logic       hmastlock,
  output logic [1:0] grant,
  output logic       addr_sel,
  output logic       data_sel,
  output logic       locked
);

  arb_state_e state;
  logic       winner;
  logic       is_nonseq;
  logic       is_end;
  logic       is_fixed;
  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_clr;
  logic       cnt_last;

  // Winner: decoder decides contention, lone requester wins, no request parks.
  always_comb begin
    winner = addr_sel;
    case (req)
      2'b11:   winner = (decod == 2'b10);
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      default: winner = addr_sel;
    endcase
  end

  assign is_nonseq = (htrans == HTRANS_NONSEQ);
  assign is_end    = (htrans == HTRANS_IDLE) || is_nonseq;
  assign is_fixed  = (hburst[2:1] != 2'b00);

  assign cnt_load = (state == ST_ARB) && is_nonseq && !hmastlock && is_fixed;
  assign cnt_dec  = (state == ST_BURST) && (htrans == HTRANS_SEQ);
  assign cnt_clr  = (state == ST_BURST) && is_end;

  ml_ahb_burst_cnt #(
    .CNT_W (CNT_W)
  ) u_burst_cnt (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .hready   (hready),
    .load     (cnt_load),
    .load_val (CNT_W'(burst_beats_m1(hburst[2:1]))),
    .dec      (cnt_dec),
    .clr      (cnt_clr),
    .last_c   (cnt_last)
  );

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= ST_ARB;
      grant    <= (DEF_MASTER != 0) ? 2'b10 : 2'b01;
      addr_sel <= 1'(DEF_MASTER);
      data_sel <= 1'(DEF_MASTER);
      locked   <= 1'b0;
    end else if (hready) begin
      data_sel <= addr_sel;
      case (state)
        ST_ARB: begin
          if (is_nonseq && hmastlock) begin
            state  <= ST_LOCK;
            locked <= 1'b1;
          end else if (is_nonseq && is_fixed) begin
            state <= ST_BURST;
          end else if (is_nonseq && (hburst == HBURST_INCR)) begin
            state <= ST_INCR;
          end else begin
            grant    <= {winner, ~winner};
            addr_sel <= winner;
          end
        end
        ST_BURST: begin
          // Normal completion hands over on the following edge; early
          // termination re-arbitrates on this edge.
          if ((htrans == HTRANS_SEQ) && cnt_last) begin
            state <= ST_ARB;
          end else if (is_end) begin
            state    <= ST_ARB;
            grant    <= {winner, ~winner};
            addr_sel <= winner;
          end
        end
        ST_INCR: begin
          if (is_end) begin
            state    <= ST_ARB;
            grant    <= {winner, ~winner};
            addr_sel <= winner;
          end
        end
        ST_LOCK: begin
          if (!hmastlock && (htrans == HTRANS_IDLE)) begin
            state  <= ST_ARB;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= ST_ARB;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ml_ahb_arb_port_1.sv
// Scoreboard bench for ml_ahb_arb_port_1: per-scenario stimulus tables push
// expected {grant,addr_sel,data_sel,locked} which are popped after each edge.
module tb_ml_ahb_arb_port_1;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NS   = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  localparam logic [2:0] B_SGL  = 3'b000;
  localparam logic [2:0] B_INC  = 3'b001;
  localparam logic [2:0] B_I4   = 3'b011;
  localparam logic [2:0] B_I8   = 3'b101;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic [1:0] req;
  logic [1:0] decod;
  logic       hready;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hmastlock;
  logic [1:0] grant;
  logic       addr_sel;
  logic       data_sel;
  logic       locked;

  logic [4:0] sb [$];
  int         n_checks = 0;
  int         n_pass   = 0;

  ml_ahb_arb_port_1 #(
    .DEF_MASTER (0),
    .CNT_W      (4)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .req       (req),
    .decod     (decod),
    .hready    (hready),
    .htrans    (htrans),
    .hburst    (hburst),
    .hmastlock (hmastlock),
    .grant     (grant),
    .addr_sel  (addr_sel),
    .data_sel  (data_sel),
    .locked    (locked)
  );

  always #5 HCLK = ~HCLK;

  // Row layout: {HRESETn, req, decod, hready, htrans, hburst, hmastlock}
  function automatic logic [11:0] row(input logic rst, input logic [1:0] rq,
                                      input logic [1:0] dc, input logic rdy,
                                      input logic [1:0] tr, input logic [2:0] bu,
                                      input logic lk);
    return {rst, rq, dc, rdy, tr, bu, lk};
  endfunction

  task automatic test_reset();
    logic [11:0] stim [2];
    logic [4:0]  expv [2];
    logic [4:0]  e;
    stim = '{row(0, 2'b00, 2'b00, 1, T_IDLE, B_SGL, 0),
             row(0, 2'b11, 2'b10, 0, T_NS,   B_I4,  1)};
    expv = '{5'b01_0_0_0, 5'b01_0_0_0};
    for (int i = 0; i < 2; i++) begin
      {HRESETn, req, decod, hready, htrans, hburst, hmastlock} = stim[i];
      sb.push_back(expv[i]);
      @(posedge HCLK); #1;
      e = sb.pop_front();
      n_checks++;
      if ({grant, addr_sel, data_sel, locked} !== e)
        $display("FAIL reset step %0d: got grant=%b addr_sel=%b data_sel=%b locked=%b, want %b",
                 i, grant, addr_sel, data_sel, locked, e);
      else n_pass++;
    end
  endtask

  task automatic test_arbitrate();
    logic [11:0] stim [7];
    logic [4:0]  expv [7];
    logic [4:0]  e;
    stim = '{row(1, 2'b11, 2'b10, 1, T_NS, B_SGL, 0),
             row(1, 2'b11, 2'b10, 1, T_NS, B_SGL, 0),
             row(1, 2'b11, 2'b01, 1, T_NS, B_SGL, 0),
             row(1, 2'b11, 2'b01, 1, T_NS, B_SGL, 0),
             row(1, 2'b10, 2'b01, 1, T_NS, B_SGL, 0),
             row(1, 2'b00, 2'b01, 1, T_NS, B_SGL, 0),
             row(1, 2'b11, 2'b00, 1, T_NS, B_SGL, 0)};
    expv = '{5'b10_1_0_0, 5'b10_1_1_0, 5'b01_0_1_0, 5'b01_0_0_0,
             5'b10_1_0_0, 5'b10_1_1_0, 5'b01_0_1_0};
    for (int i = 0; i < 7; i++) begin
      {HRESETn, req, decod, hready, htrans, hburst, hmastlock} = stim[i];
      sb.push_back(expv[i]);
      @(posedge HCLK); #1;
      e = sb.pop_front();
      n_checks++;
      if ({grant, addr_sel, data_sel, locked} !== e)
        $display("FAIL arbitrate step %0d: got grant=%b addr_sel=%b data_sel=%b locked=%b, want %b",
                 i, grant, addr_sel, data_sel, locked, e);
      else n_pass++;
    end
  endtask

  task automatic test_burst_hold();
    logic [11:0] stim [12];
    logic [4:0]  expv [12];
    logic [4:0]  e;
    stim = '{row(1, 2'b11, 2'b10, 1, T_NS,   B_I4, 0),
             row(1, 2'b11, 2'b10, 1, T_SEQ,  B_I4, 0),
             row(1, 2'b11, 2'b10, 1, T_SEQ,  B_I4, 0),
             row(1, 2'b11, 2'b10, 1, T_SEQ,  B_I4, 0),
             row(1, 2'b11, 2'b10, 1, T_IDLE, B_I4, 0),
             row(1, 2'b01, 2'b10, 1, T_IDLE, B_I4, 0),
             row(1, 2'b11, 2'b10, 1, T_NS,   B_I4, 0),
             row(1, 2'b11, 2'b10, 1, T_SEQ,  B_I4, 0),
             row(1, 2'b11, 2'b10, 1, T_BUSY, B_I4, 0),
             row(1, 2'b11, 2'b10, 1, T_SEQ,  B_I4, 0),
             row(1, 2'b11, 2'b10, 1, T_SEQ,  B_I4, 0),
             row(1, 2'b11, 2'b10, 1, T_IDLE, B_I4, 0)};
    expv = '{5'b01_0_0_0, 5'b01_0_0_0, 5'b01_0_0_0, 5'b01_0_0_0,
             5'b10_1_0_0, 5'b01_0_1_0, 5'b01_0_0_0, 5'b01_0_0_0,
             5'b01_0_0_0, 5'b01_0_0_0, 5'b01_0_0_0, 5'b10_1_0_0};
    for (int i = 0; i < 12; i++) begin
      {HRESETn, req, decod, hready, htrans, hburst, hmastlock} = stim[i];
      sb.push_back(expv[i]);
      @(posedge HCLK); #1;
      e = sb.pop_front();
      n_checks++;
      if ({grant, addr_sel, data_sel, locked} !== e)
        $display("FAIL burst_hold step %0d: got grant=%b addr_sel=%b data_sel=%b locked=%b, want %b",
                 i, grant, addr_sel, data_sel, locked, e);
      else n_pass++;
    end
  endtask

  task automatic test_incr_abort();
    logic [11:0] stim [11];
    logic [4:0]  expv [11];
    logic [4:0]  e;
    stim = '{row(1, 2'b01, 2'b00, 1, T_IDLE, B_SGL, 0),
             row(1, 2'b10, 2'b00, 1, T_NS,   B_I8,  0),
             row(1, 2'b10, 2'b00, 1, T_SEQ,  B_I8,  0),
             row(1, 2'b10, 2'b00, 1, T_SEQ,  B_I8,  0),
             row(1, 2'b10, 2'b00, 1, T_IDLE, B_I8,  0),
             row(1, 2'b11, 2'b01, 1, T_SEQ,  B_I8,  0),
             row(1, 2'b11, 2'b10, 1, T_NS,   B_INC, 0),
             row(1, 2'b11, 2'b10, 1, T_SEQ,  B_INC, 0),
             row(1, 2'b11, 2'b10, 1, T_BUSY, B_INC, 0),
             row(1, 2'b11, 2'b10, 1, T_SEQ,  B_INC, 0),
             row(1, 2'b11, 2'b10, 1, T_NS,   B_SGL, 0)};
    expv = '{5'b01_0_1_0, 5'b01_0_0_0, 5'b01_0_0_0, 5'b01_0_0_0,
             5'b10_1_0_0, 5'b01_0_1_0, 5'b01_0_0_0, 5'b01_0_0_0,
             5'b01_0_0_0, 5'b01_0_0_0, 5'b10_1_0_0};
    for (int i = 0; i < 11; i++) begin
      {HRESETn, req, decod, hready, htrans, hburst, hmastlock} = stim[i];
      sb.push_back(expv[i]);
      @(posedge HCLK); #1;
      e = sb.pop_front();
      n_checks++;
      if ({grant, addr_sel, data_sel, locked} !== e)
        $display("FAIL incr_abort step %0d: got grant=%b addr_sel=%b data_sel=%b locked=%b, want %b",
                 i, grant, addr_sel, data_sel, locked, e);
      else n_pass++;
    end
  endtask

  task automatic test_lock();
    logic [11:0] stim [6];
    logic [4:0]  expv [6];
    logic [4:0]  e;
    stim = '{row(1, 2'b11, 2'b01, 1, T_NS,   B_SGL, 1),
             row(1, 2'b11, 2'b01, 1, T_NS,   B_SGL, 1),
             row(1, 2'b11, 2'b01, 1, T_NS,   B_SGL, 1),
             row(1, 2'b11, 2'b01, 1, T_IDLE, B_SGL, 1),
             row(1, 2'b11, 2'b01, 1, T_IDLE, B_SGL, 0),
             row(1, 2'b11, 2'b01, 1, T_IDLE, B_SGL, 0)};
    expv = '{5'b10_1_1_1, 5'b10_1_1_1, 5'b10_1_1_1, 5'b10_1_1_1,
             5'b10_1_1_0, 5'b01_0_1_0};
    for (int i = 0; i < 6; i++) begin
      {HRESETn, req, decod, hready, htrans, hburst, hmastlock} = stim[i];
      sb.push_back(expv[i]);
      @(posedge HCLK); #1;
      e = sb.pop_front();
      n_checks++;
      if ({grant, addr_sel, data_sel, locked} !== e)
        $display("FAIL lock step %0d: got grant=%b addr_sel=%b data_sel=%b locked=%b, want %b",
                 i, grant, addr_sel, data_sel, locked, e);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic [11:0] stim [10];
    logic [4:0]  expv [10];
    logic [4:0]  e;
    stim = '{row(1, 2'b11, 2'b10, 1, T_NS,   B_I4, 0),
             row(1, 2'b11, 2'b10, 1, T_SEQ,  B_I4, 0),
             row(1, 2'b11, 2'b01, 0, T_SEQ,  B_I4, 0),
             row(1, 2'b11, 2'b10, 0, T_SEQ,  B_I4, 0),
             row(1, 2'b11, 2'b01, 0, T_SEQ,  B_I4, 0),
             row(1, 2'b11, 2'b10, 0, T_SEQ,  B_I4, 0),
             row(1, 2'b11, 2'b01, 0, T_SEQ,  B_I4, 0),
             row(1, 2'b11, 2'b10, 1, T_SEQ,  B_I4, 0),
             row(1, 2'b11, 2'b10, 1, T_SEQ,  B_I4, 0),
             row(1, 2'b11, 2'b10, 1, T_IDLE, B_I4, 0)};
    expv = '{5'b01_0_0_0, 5'b01_0_0_0, 5'b01_0_0_0, 5'b01_0_0_0,
             5'b01_0_0_0, 5'b01_0_0_0, 5'b01_0_0_0, 5'b01_0_0_0,
             5'b01_0_0_0, 5'b10_1_0_0};
    for (int i = 0; i < 10; i++) begin
      {HRESETn, req, decod, hready, htrans, hburst, hmastlock} = stim[i];
      sb.push_back(expv[i]);
      @(posedge HCLK); #1;
      e = sb.pop_front();
      n_checks++;
      if ({grant, addr_sel, data_sel, locked} !== e)
        $display("FAIL stall step %0d: got grant=%b addr_sel=%b data_sel=%b locked=%b, want %b",
                 i, grant, addr_sel, data_sel, locked, e);
      else n_pass++;
    end
  endtask

  task automatic test_stall_reset();
    logic [11:0] stim [6];
    logic [4:0]  expv [6];
    logic [4:0]  e;
    stim = '{row(1, 2'b11, 2'b01, 0, T_IDLE, B_SGL, 0),
             row(1, 2'b11, 2'b10, 1, T_NS,   B_I8,  0),
             row(1, 2'b11, 2'b10, 1, T_SEQ,  B_I8,  0),
             row(1, 2'b11, 2'b01, 0, T_SEQ,  B_I8,  0),
             row(0, 2'b11, 2'b01, 0, T_SEQ,  B_I8,  0),
             row(1, 2'b11, 2'b10, 1, T_SEQ,  B_I8,  0)};
    expv = '{5'b10_1_0_0, 5'b10_1_1_0, 5'b10_1_1_0, 5'b10_1_1_0,
             5'b01_0_0_0, 5'b10_1_0_0};
    for (int i = 0; i < 6; i++) begin
      {HRESETn, req, decod, hready, htrans, hburst, hmastlock} = stim[i];
      sb.push_back(expv[i]);
      @(posedge HCLK); #1;
      e = sb.pop_front();
      n_checks++;
      if ({grant, addr_sel, data_sel, locked} !== e)
        $display("FAIL stall_reset step %0d: got grant=%b addr_sel=%b data_sel=%b locked=%b, want %b",
                 i, grant, addr_sel, data_sel, locked, e);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_arbitrate();
    test_burst_hold();
    test_incr_abort();
    test_lock();
    test_stall();
    test_stall_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
